// File: rtl/midi_uart_pkg.sv
// Shared constants for the MIDI UART transmitter and receiver: baud divider,
// frame geometry and the legacy 4-bit state encodings.
package midi_uart_pkg;

    localparam int MIDI_CLK_DIV  = 100;
    localparam int TICKS_PER_BIT = 16;
    localparam int DATA_BITS     = 8;

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] START = 4'd1;
    localparam logic [3:0] DATA  = 4'd2;
    localparam logic [3:0] STOP  = 4'd3;

    localparam logic [3:0] LAST_TICK = 4'(TICKS_PER_BIT - 1);

endpackage

// File: rtl/midi_baud_tick.sv
// Free-running divider producing a one-cycle 16x baud tick; the first tick
// is high during the CLK_DIV-th cycle after reset release.
module midi_baud_tick #(
    parameter int CLK_DIV = 100
) (
    input  logic clk,
    input  logic reset,
    output logic bclk
);

    localparam int CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] WRAP = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (cnt == WRAP)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

    assign bclk = (cnt == WRAP);

endmodule

// File: rtl/midi_uart_tx.sv
// MIDI OUT transmitter: 8N1, LSB first, fed from a small FIFO so that queued
// bytes go out back-to-back. Drain interrupt with ack for the PicoBlaze.
module midi_uart_tx
    import midi_uart_pkg::*;
#(
    parameter int CLK_DIV = MIDI_CLK_DIV,
    parameter int FIFO_AW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       write,
    output logic       txd,
    output logic       busy,
    output logic       full,
    output logic       empty,
    output logic       overrun,
    output logic       interrupt,
    input  logic       interrupt_ack,
    output logic [3:0] CS
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic               bclk;
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] head, tail;
    logic [FIFO_AW:0]   count;
    logic               push, pop, last_tick, drain;
    logic [3:0]         state, tick;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;

    midi_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .bclk  (bclk)
    );

    assign full      = (count == (FIFO_AW+1)'(DEPTH));
    assign empty     = (count == '0);
    assign push      = write & ~full;
    assign last_tick = bclk & (tick == LAST_TICK);
    // The FSM loads mem[head] under exactly these conditions.
    assign pop       = ~empty & bclk &
                       ((state == IDLE) | ((state == STOP) & (tick == LAST_TICK)));
    assign drain     = last_tick & (state == STOP) & empty;
    assign busy      = (state != IDLE) | ~empty;
    assign CS        = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) tail <= tail + FIFO_AW'(1);
            if (pop)  head <= head + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (FIFO_AW+1)'(1);
                2'b01:   count <= count - (FIFO_AW+1)'(1);
                default: ;
            endcase
            if (write && full) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[tail] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            tick    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            txd     <= 1'b1;
        end else if (bclk) begin
            case (state)
                IDLE: begin
                    tick <= '0;
                    txd  <= 1'b1;
                    if (!empty) begin
                        shift <= mem[head];
                        state <= START;
                        txd   <= 1'b0;
                    end
                end
                START: begin
                    tick <= tick + 4'd1;
                    if (tick == LAST_TICK) begin
                        state   <= DATA;
                        txd     <= shift[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    tick <= tick + 4'd1;
                    if (tick == LAST_TICK) begin
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
                            state <= STOP;
                            txd   <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            txd     <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                STOP: begin
                    tick <= tick + 4'd1;
                    if (tick == LAST_TICK) begin
                        if (!empty) begin
                            shift <= mem[head];
                            state <= START;
                            txd   <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tick  <= '0;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            interrupt <= 1'b0;
        else if (drain)
            interrupt <= 1'b1;
        else if (interrupt_ack)
            interrupt <= 1'b0;
    end

endmodule

// File: tb/tb_midi_uart_tx.sv
// Scoreboard bench for midi_uart_tx: writes push expected bytes, a serial
// monitor decodes txd frames and compares them against the queue.
module tb_midi_uart_tx;

    localparam int DIV   = 10;
    localparam int BIT   = 16 * DIV;
    localparam int FRAME = 10 * BIT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = 8'h00;
    logic       write = 1'b0;
    logic       interrupt_ack = 1'b0;
    logic       txd, busy, full, empty, overrun, interrupt;
    logic [3:0] CS;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nframes = 0;
    logic [7:0] exp_q[$];
    int starts[$];

    midi_uart_tx #(.CLK_DIV(DIV), .FIFO_AW(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .din           (din),
        .write         (write),
        .txd           (txd),
        .busy          (busy),
        .full          (full),
        .empty         (empty),
        .overrun       (overrun),
        .interrupt     (interrupt),
        .interrupt_ack (interrupt_ack),
        .CS            (CS)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Serial monitor: sample each bit mid-way, compare byte with scoreboard.
    logic       mon_on = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;
    always @(negedge clk) begin
        if (reset) begin
            mon_on = 1'b0;
        end else if (!mon_on) begin
            if (txd === 1'b0) begin
                mon_on  = 1'b1;
                mon_cnt = 0;
                starts.push_back(cyc);
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == BIT/2)
                chk("start_bit", txd, 1'b0);
            else if (mon_cnt > BIT/2 && mon_cnt < BIT/2 + 9*BIT && (mon_cnt - BIT/2) % BIT == 0)
                mon_byte = {txd, mon_byte[7:1]};
            else if (mon_cnt == BIT/2 + 9*BIT) begin
                chk("stop_bit", txd, 1'b1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame: got %0h expected none", mon_byte);
                end else begin
                    chk("frame_byte", mon_byte, exp_q.pop_front());
                end
                nframes++;
                mon_on = 1'b0;
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] b, input logic expect_sent);
        din   = b;
        write = 1'b1;
        if (expect_sent) exp_q.push_back(b);
        step();
        write = 1'b0;
    endtask

    task automatic wait_start(input int idx, input int budget, output int s);
        int n = 0;
        while (starts.size() <= idx && n < budget) begin
            step();
            n++;
        end
        if (starts.size() > idx) s = starts[idx];
        else begin
            s = cyc;
            total++;
            bad++;
            $display("FAIL start_timeout: got %0d starts expected %0d", starts.size(), idx + 1);
        end
    endtask

    task automatic wait_irq(input int budget, output int t);
        int n = 0;
        while (interrupt !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        t = cyc;
        chk("irq_seen", interrupt, 1'b1);
    endtask

    initial begin
        int s_w, s0, s1, s2, s3, s4, t, busy_lo, lows, d;

        // reset state
        step(3);
        chk("rst_txd", txd, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_irq", interrupt, 1'b0);
        chk("rst_cs", CS, 4'd0);
        reset = 1'b0;
        step(5);

        // single frame 0x90
        s_w = cyc + 1;
        wr(8'h90, 1'b1);
        chk("t1_empty_after_write", empty, 1'b0);
        wait_start(0, 2*DIV + 5, s0);
        chk("t1_latency", (s0 - s_w >= 1) && (s0 - s_w <= DIV + 1), 1'b1);
        chk("t1_cs_start", CS, 4'd1);
        wait_irq(FRAME + 50, t);
        chk("t1_frame_len", t - s0, FRAME);
        chk("t1_nframes", nframes, 1);
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        chk("t1_irq_cleared", interrupt, 1'b0);

        // three back-to-back frames, ack coinciding with drain
        step(7);
        wr(8'h90, 1'b1);
        wr(8'h3C, 1'b1);
        wr(8'h64, 1'b1);
        wait_start(1, 2*DIV + 5, s1);
        chk("t2_empty_mid", empty, 1'b0);
        busy_lo = 0;
        d = 0;
        while (starts.size() < 4 && d < 3*FRAME) begin
            step();
            d++;
            if (busy !== 1'b1) busy_lo++;
        end
        if (starts.size() >= 4) begin
            s2 = starts[2];
            s3 = starts[3];
        end else begin
            s2 = 0;
            s3 = cyc;
        end
        chk("t2_empty_after_pop3", empty, 1'b1);
        chk("t2_gap12", s2 - s1, FRAME);
        chk("t2_gap23", s3 - s2, FRAME);
        while (cyc < s3 + FRAME - 1) begin
            step();
            if (busy !== 1'b1) busy_lo++;
        end
        chk("t2_no_irq_before_drain", interrupt, 1'b0);
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        chk("t2_busy_lo", busy_lo, 0);
        chk("t2_irq_set_wins", interrupt, 1'b1);
        chk("t2_busy_done", busy, 1'b0);
        step(9);
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;
        chk("t2_irq_ack_later", interrupt, 1'b0);
        chk("t2_nframes", nframes, 4);

        // five writes right after a bclk: fifth dropped
        while ((cyc - s3) % DIV != 0) step();
        chk("t3_overrun_pre", overrun, 1'b0);
        wr(8'h11, 1'b1);
        wr(8'h22, 1'b1);
        wr(8'h33, 1'b1);
        wr(8'h44, 1'b1);
        chk("t3_full", full, 1'b1);
        wr(8'hEE, 1'b0);
        chk("t3_overrun", overrun, 1'b1);
        wait_irq(4*FRAME + 3*DIV, t);
        chk("t3_nframes", nframes, 8);
        chk("t3_queue_drained", exp_q.size(), 0);
        interrupt_ack = 1'b1;
        step();
        interrupt_ack = 1'b0;

        // reset in the middle of data bit 3 of 0x55
        step(5);
        wr(8'h55, 1'b1);
        wait_start(8, 2*DIV + 5, s4);
        wr(8'hAA, 1'b0);
        while (cyc < s4 + 4*BIT + BIT/2) step();
        chk("t4_txd_bit3", txd, 1'b0);
        reset = 1'b1;
        #1;
        chk("t4_txd_async", txd, 1'b1);
        chk("t4_empty", empty, 1'b1);
        chk("t4_busy", busy, 1'b0);
        chk("t4_cs", CS, 4'd0);
        chk("t4_overrun_cleared", overrun, 1'b0);
        exp_q.delete();
        step(3);
        reset = 1'b0;
        lows = 0;
        repeat (3*FRAME) begin
            step();
            if (txd !== 1'b1) lows++;
        end
        chk("t4_txd_idle", lows, 0);
        chk("t4_no_new_start", starts.size(), 9);
        chk("t4_nframes", nframes, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_uart_tx.md
# midi_uart_tx

MIDI-rate UART transmitter, 8N1 with LSB first, at 31.25 kbaud from a 50 MHz `clk`. It is the outbound counterpart of the MIDI receiver and sits between the PicoBlaze output port and the MIDI OUT pin. Bytes are queued in a small FIFO and sent back-to-back with no idle gap. It provides status flags and an interrupt/ack pair for the PicoBlaze.

## Interface
- `CLK_DIV`, 100: `clk` cycles per 16x baud tick (50 MHz / (16 × 31250)).
- `FIFO_AW`, 2: FIFO address width; depth = 2^`FIFO_AW` (4).

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock, 50 MHz
- `reset`  in  1  asynchronous, active-high; clears all state
- `din`  in  8  byte to send
- `write`  in  1  one-cycle write strobe; queues `din`
- `txd`  out  1  serial output; idles high
- `busy`  out  1  frame in progress, or FIFO not empty
- `full`  out  1  FIFO holds 2^`FIFO_AW` entries
- `empty`  out  1  FIFO holds 0 entries
- `overrun`  out  1  sticky: a write was dropped
- `interrupt`  out  1  transmitter drained; held until acked
- `interrupt_ack`  in  1  clears `interrupt`
- `CS`  out  4  current state, for debug

Reset values: `txd`=1, `busy`=0, `full`=0, `empty`=1, `overrun`=0, `interrupt`=0, `CS`=IDLE (0).

## Operation
- Baud tick
  - Free-running counter 0..`CLK_DIV`-1.
  - `bclk` pulses high for one cycle when the counter wraps.
  - First pulse comes `CLK_DIV` cycles after reset release.
- FIFO
  - `write` with `full`=0 stores `din` at the tail.
  - `write` with `full`=1 drops the byte and sets `overrun`. `full` is the pre-edge value, even if a pop happens in the same cycle.
  - A pop happens only when `empty`=0, so a write and a pop in the same cycle are both honoured.
- State machine. The state changes only on `bclk` cycles. A 4-bit tick counter counts 16 ticks per bit.
  - IDLE (0): on `bclk` with `empty`=0, pop a byte into the shift register and go to START.
  - START (1): `txd`=0 for 16 ticks, then go to DATA.
  - DATA (2): `txd`=shift[0]; shift right every 16 ticks; after the 8th bit go to STOP.
  - STOP (3): `txd`=1 for 16 ticks. At the end, if `empty`=0, pop and go to START (back-to-back); otherwise go to IDLE and raise the drain event.
  - Codes 4–15 are illegal and go to IDLE with `txd`=1.
- `txd` is a registered output. It is glitch-free.
- `busy` = (state≠IDLE) | !`empty`.
- Interrupt
  - Set on the drain event (one cycle).
  - Cleared by `interrupt_ack`.
  - If set and ack coincide, set wins.
- `overrun` is cleared only by `reset`.
- Reset mid-frame
  - `txd` goes high asynchronously.
  - The FIFO and the partial frame are discarded.
  - No further frames are sent.

## Timing
- Bit time: 16 × `CLK_DIV` = 1600 clocks (32 µs).
- Frame: 10 bits = 16000 clocks.
- Write to start-bit latency, with FIFO empty and state IDLE: 1 to `CLK_DIV`+1 clocks. `txd` falls on the clock after the first `bclk` that sees the byte.
- Back-to-back frames: the next start bit begins on the clock after the last stop-bit tick. Gap = 0.
- `full`/`empty` update one clock after the write or pop edge.
- `interrupt` rises one clock after the final stop-bit tick.

## Structure
- Package `midi_uart_pkg`, shared with the receiver:
  - `MIDI_CLK_DIV`=100
  - `TICKS_PER_BIT`=16
  - `DATA_BITS`=8
  - state encodings IDLE/START/DATA/STOP
- Sub-module `midi_baud_tick`: parameterised `CLK_DIV` divider producing `bclk`. The receiver can reuse it.
- FIFO: inline, with register array, head/tail pointers and an occupancy counter of `FIFO_AW`+1 bits.

## Test plan
- Reset, then write 0x90.
  - `txd`=0 for 1600 clocks, then data 0,0,0,0,1,0,0,1 at 1600 clocks each, then stop =1.
  - Frame lasts 16000 clocks; `interrupt`=1 one clock after the stop bit ends.
- Write 0x90, 0x3C, 0x64 in three consecutive cycles.
  - Three contiguous frames, 48000 clocks, no idle between stop and start.
  - `busy`=1 throughout; `empty`=1 after the third pop.
- Issue five writes in consecutive cycles immediately after a `bclk`.
  - `full`=1 after the 4th write; the 5th is dropped and `overrun`=1.
  - Exactly 4 frames are sent.
- Assert `reset` during data bit 3 of 0x55.
  - `txd`=1 immediately; `empty`=1, `busy`=0.
  - No start bit follows release.
- Pulse `interrupt_ack` in the same cycle as the drain event.
  - `interrupt` stays 1; an ack 10 clocks later clears it to 0.
